// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and the elaboration-time width helper
// used by the counter primitives.
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Number of bits needed to hold the values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single-bit synchronous JK flip-flop with synchronous active-high reset to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TOG:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MOD up/down counter built from JK cells, with parallel load (clamped),
// enable, combinational terminal count and a registered wrap pulse.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  generate
    if (WIDTH < 1 || WIDTH > 16 || MOD < 2 || clog2(MOD) > WIDTH) begin : g_bad_params
      $fatal(1, "jk_sync_counter: illegal WIDTH/MOD combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] nxt;
  logic             wrap_nxt;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  // Widened compares keep MOD == 2**WIDTH correct without overflow.
  always_comb begin
    nxt      = q;
    wrap_nxt = 1'b0;
    if (load) begin
      nxt = (32'(din) >= 32'(MOD)) ? MAXV : din;
    end else if (en) begin
      if (32'(q) >= 32'(MOD)) begin
        nxt      = '0;
        wrap_nxt = 1'b1;
      end else if (up_dn) begin
        if (q == MAXV) begin
          nxt      = '0;
          wrap_nxt = 1'b1;
        end else begin
          nxt = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          nxt      = MAXV;
          wrap_nxt = 1'b1;
        end else begin
          nxt = q - 1'b1;
        end
      end
    end
  end

  assign j  = nxt & ~q;
  assign k  = ~nxt & q;
  assign tc = (up_dn && (q == MAXV)) || (!up_dn && (q == '0));

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
        .clk   (clk),
        .reset (reset),
        .j     (j[i]),
        .k     (k[i]),
        .q     (q[i])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
Parametrised synchronous modulo-N up/down counter. Every state bit is a JK flip-flop cell, and the J/K inputs for each cell come from next-state logic. The block extends the team's single-bit synchronous JK flip-flop with configurable width, modulus, direction, parallel load, enable and terminal-count/wrap signalling. It is the standard counter primitive for timers, dividers and sequencers in the 100-days design set.

Parameters:
WIDTH, 4, number of counter bits (JK cells); legal range 1..16
MOD, 10, count modulus; counter sequence is 0..MOD-1; legal range 2..2**WIDTH (elaboration-time check, fatal if violated)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
en  input  1  count enable; counter holds when low
up_dn  input  1  direction: 1 = count up, 0 = count down
load  input  1  parallel load strobe
din  input  WIDTH  parallel load value
q  output  WIDTH  current count (registered, direct from JK cells)
tc  output  1  terminal count, combinational: (up_dn && q==MOD-1) || (!up_dn && q==0)
wrap  output  1  registered one-cycle pulse: the count wrapped on the previous edge

Behaviour:
- Clocking: all state changes on the rising edge of clk only. One clock; reset is synchronous and active-high.
- Reset values: q = 0, wrap = 0. The tc output follows from q (after reset, tc = 1 when up_dn = 0, else 0).
- Priority at each edge: reset > load > en > hold.
- Load:
  - q <= din when din <= MOD-1.
  - If din >= MOD, q <= MOD-1 (clamp).
  - wrap <= 0.
  - en is ignored during load.
- Count up (en=1, up_dn=1):
  - q <= q+1.
  - If q == MOD-1, q <= 0 and wrap <= 1.
- Count down (en=1, up_dn=0):
  - q <= q-1.
  - If q == 0, q <= MOD-1 and wrap <= 1.
- Hold (en=0, no load): q unchanged, wrap <= 0.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps (e.g. MOD=2 continuous counting) hold wrap high on consecutive cycles.
- Direction change mid-count takes effect on the same edge. There is no pipeline; latency from inputs to q is one edge.
- Out-of-range state cannot arise from count or load. Defensive rule: if q >= MOD while en=1, the next state is 0 in either direction, with wrap <= 1.
- JK derivation, per bit i, with nxt = computed next state:
  - J_i = nxt_i & ~q_i
  - K_i = ~nxt_i & q_i
  - Unchanged bits see J=K=0 (hold).
  - The cell reset is driven from the top-level reset.
- MOD == 2**WIDTH: the wrap compare reduces to natural overflow. Behaviour is identical to the rules above.
- Reset mid-operation: reset asserted on any edge overrides load and en. The next cycle starts from q=0, wrap=0.

Decomposition:
- Shared package (jk_pkg): the JK encoding constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TOG=2'b11.
- The package also holds a function clog2 for WIDTH checks.
- One sub-module, jk_cell:
  - Single-bit synchronous JK flip-flop with ports clk, reset, j, k, q.
  - Reset is synchronous and active-high, to q=0.
  - Nonblocking assignments.
  - Instantiated WIDTH times via generate.
- Next-state, clamp, tc and wrap logic sit in jk_sync_counter.

Test Plan:
- Reset: hold reset=1 for 2 edges with en=1, load=1, din=7 -> q=0, wrap=0. With up_dn=1, tc=0 after release.
- Up wrap (WIDTH=4, MOD=10): en=1, up_dn=1 for 12 edges from 0 -> q counts 1..9,0,1,2. tc=1 while q=9. wrap=1 only in the cycle after the 9->0 edge.
- Down wrap: load din=2, then en=1, up_dn=0 for 4 edges -> q=2,1,0,9,8. wrap pulses once after the 0->9 edge.
- Load clamp and priority: load=1, en=1, din=13 -> q=9, wrap=0. Next edge with load=0, en=1, up -> q=0, wrap=1.
- Hold and direction flip: en=0 for 3 edges at q=5 -> q stays 5. Then toggle up_dn every edge with en=1 -> q=6,5,6,5.
- Full-range (WIDTH=3, MOD=8) plus mid-count reset: count up from 0 -> q=7 then 0 with wrap. Assert reset at q=4 -> next q=0.
